// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    // Operand width used when the top is instantiated without overrides.
    localparam int SEQ_MULT_N_DEF = 4;

    // Controller states: waiting, iterating over multiplier bits, result held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Extend the low n bits of v to 64 bits, sign-extending when sgn is set.
    // Callers truncate to 2N bits; operands are at most 32 bits wide.
    function automatic logic [63:0] seq_mult_ext(input logic [31:0] v,
                                                 input int          n,
                                                 input logic        sgn);
        logic [63:0] r;
        logic        fill;
        fill = sgn & v[n-1];
        r    = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < n) ? v[i] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One shift-add step: folds (pp << sh) into the accumulator when the
// current multiplier bit is set, subtracting instead for a signed MSB.
module mult_pp_step #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic [W-1:0]  acc_i,
    input  logic [W-1:0]  pp_i,
    input  logic [SW-1:0] sh_i,
    input  logic          en_i,
    input  logic          sub_i,
    output logic [W-1:0]  acc_o
);

    logic [W-1:0] pp_sh;

    assign pp_sh = pp_i << sh_i;

    // Add or subtract the weighted partial product, modulo 2^W.
    always_comb begin
        acc_o = acc_i;
        if (en_i) begin
            acc_o = sub_i ? (acc_i - pp_sh) : (acc_i + pp_sh);
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential N x N -> 2N shift-add multiplier, one multiplier bit per clock,
// unsigned or two's-complement selected per operation, START/BUSY/DONE
// handshake. Optional macro SEQ_MULT_EARLY_TERM_EN finishes as soon as the
// remaining multiplier bits are all zero.
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int N  = SEQ_MULT_N_DEF,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic           SIGNED_MODE,
    input  logic [N-1:0]   PLICAND,
    input  logic [N-1:0]   PLIER,
    output logic           BUSY,
    output logic           DONE,
    output logic [2*N-1:0] PRODUCT,
    output logic [N-1:0]   M,
    output logic [N-1:0]   Q
);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   q_q, q_d;
    logic           mode_q, mode_d;

    logic [2*N-1:0] mext;
    logic [2*N-1:0] acc_step;
    logic           last_bit;
    logic [N-1:0]   q_shr;
    logic           finish;

    assign mext     = (2*N)'(seq_mult_ext(32'(m_q), N, mode_q));
    assign last_bit = (cnt_q == CW'(N - 1));
    assign q_shr    = q_q >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
    // A zero remainder contributes nothing further, including the signed MSB.
    assign finish = last_bit || (q_shr == '0);
`else
    assign finish = last_bit;
`endif

    mult_pp_step #(
        .W  (2 * N),
        .SW (CW)
    ) u_step (
        .acc_i (acc_q),
        .pp_i  (mext),
        .sh_i  (cnt_q),
        .en_i  (q_q[0]),
        .sub_i (mode_q & last_bit),
        .acc_o (acc_step)
    );

    // Next-state, operand latch and accumulate control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        m_d     = m_q;
        q_d     = q_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (START) begin
                    state_d = CALC;
                    m_d     = PLICAND;
                    q_d     = PLIER;
                    mode_d  = SIGNED_MODE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                acc_d = acc_step;
                q_d   = q_shr;
                cnt_d = cnt_q + CW'(1);
                if (finish) begin
                    prod_d  = acc_step;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            m_q     <= '0;
            q_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            m_q     <= m_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
        end
    end

    assign BUSY    = (state_q == CALC);
    assign DONE    = (state_q == FIN);
    assign PRODUCT = prod_q;
    assign M       = m_q;
    assign Q       = q_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult (N=4). Expected latency follows
// SEQ_MULT_EARLY_TERM_EN when the bench is built with the same define.
module tb_seq_shift_add_mult;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic           START = 1'b0;
    logic           SIGNED_MODE = 1'b0;
    logic [N-1:0]   PLICAND = '0;
    logic [N-1:0]   PLIER = '0;
    logic           BUSY, DONE;
    logic [2*N-1:0] PRODUCT;
    logic [N-1:0]   M, Q;

    int total = 0;
    int bad   = 0;
    int cyc;

    seq_shift_add_mult #(.N(N)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .SIGNED_MODE (SIGNED_MODE),
        .PLICAND     (PLICAND),
        .PLIER       (PLIER),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .PRODUCT     (PRODUCT),
        .M           (M),
        .Q           (Q)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected cycles from accepted START to DONE for a given multiplier.
    function automatic int exp_lat(input logic [N-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int h;
        h = 1;
        for (int i = 0; i < N; i++) if (b[i]) h = i + 1;
        return h;
`else
        return (b == '0) ? N : N;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present operands with START for one edge; the accepted edge is cycle 0.
    task automatic launch(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b);
        SIGNED_MODE = sm;
        PLICAND     = a;
        PLIER       = b;
        START       = 1'b1;
        tick();
        START       = 1'b0;
    endtask

    // Advance until DONE, counting edges from the accepted START; bounded.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!DONE && c < 40) begin
            tick();
            c++;
        end
    endtask

    task automatic run(input string tag, input logic sm, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [2*N-1:0] expp);
        launch(sm, a, b);
        wait_done(0, cyc);
        chk({tag, "_lat"}, cyc, exp_lat(b));
        chk({tag, "_prod"}, PRODUCT, expp);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    initial begin
        // Reset values.
        #12;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_prod", PRODUCT, 0);
        chk("rst_m", M, 0);
        chk("rst_q", Q, 0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Unsigned 15 x 15; check operand latch right after START.
        launch(1'b0, 4'hF, 4'hF);
        chk("u_busy0", BUSY, 1);
        chk("u_done0", DONE, 0);
        chk("u_m0", M, 4'hF);
        chk("u_q0", Q, 4'hF);
        wait_done(0, cyc);
        chk("u_lat", cyc, exp_lat(4'hF));
        chk("u_prod", PRODUCT, 8'hE1);
        chk("u_qend", Q, 0);

        // Signed extremes.
        run("s_m8m8", 1'b1, 4'h8, 4'h8, 8'h40);
        run("s_7m8", 1'b1, 4'h7, 4'h8, 8'hC8);
        run("s_m1p1", 1'b1, 4'hF, 4'h1, 8'hFF);
        // Same bit pattern unsigned: 15 x 8.
        run("u_15x8", 1'b0, 4'hF, 4'h8, 8'h78);

        // START while busy is ignored: 5 x 11 with a 2 x 2 pulse mid-run.
        launch(1'b0, 4'd5, 4'd11);
        tick();
        PLICAND = 4'd2;
        PLIER   = 4'd2;
        START   = 1'b1;
        tick();
        START   = 1'b0;
        chk("busy_m", M, 4'd5);
        chk("busy_busy", BUSY, 1);
        wait_done(2, cyc);
        chk("busy_lat", cyc, 4);
        chk("busy_prod", PRODUCT, 8'd55);

        // Asynchronous reset mid-run clears everything before the next edge.
        launch(1'b0, 4'd9, 4'd9);
        tick();
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        chk("arst_prod", PRODUCT, 0);
        chk("arst_m", M, 0);
        #1;
        RESET = 1'b1;
        tick();
        run("rerun_9x9", 1'b0, 4'd9, 4'd9, 8'h51);

        // Back-to-back: START held from FIN; old PRODUCT kept during the run.
        SIGNED_MODE = 1'b0;
        PLICAND     = 4'd6;
        PLIER       = 4'd7;
        START       = 1'b1;
        tick();
        chk("b2b_done", DONE, 0);
        chk("b2b_busy", BUSY, 1);
        chk("b2b_hold", PRODUCT, 8'h51);
        wait_done(0, cyc);
        START = 1'b0;
        chk("b2b_lat", cyc, exp_lat(4'd7));
        chk("b2b_prod", PRODUCT, 8'd42);

        // Short multipliers: latency depends on the early-termination build.
        run("et_12x1", 1'b0, 4'd12, 4'd1, 8'd12);
        run("et_zero", 1'b1, 4'd9, 4'd0, 8'd0);
        run("s_m3x5", 1'b1, 4'hD, 4'd5, 8'hF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
